// File: rtl/fir_io_sequencer_if.sv
// Stream and register-bus signals of the FIR I/O sequencer.
// master = the sequencer, slave = its environment (sources, sink, FIR peripheral).
interface fir_io_sequencer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] coef_data;
  logic        coef_first;
  logic        coef_valid;
  logic        coef_ready;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_ready;
  logic        busy;
  logic [2:0]  ioaddr;
  logic        iocs;
  logic        iowr;
  logic        iord;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        err;

  modport master (
    input  s_data, s_valid, coef_data, coef_first, coef_valid, r_ready, io_rdata,
    output s_ready, coef_ready, r_data, r_valid, busy,
           ioaddr, iocs, iowr, iord, io_wdata, err
  );
  modport slave (
    output s_data, s_valid, coef_data, coef_first, coef_valid, r_ready, io_rdata,
    input  s_ready, coef_ready, r_data, r_valid, busy,
           ioaddr, iocs, iowr, iord, io_wdata, err
  );
endinterface

// File: rtl/fir_io_sequencer.sv
// Bus-master sequencer for the 128-tap FIR peripheral: coefficient load, sample feed, status poll, result read.
// Optional bounded polling with err pulse: define FIRSEQ_TIMEOUT_EN.
module fir_io_sequencer #(
  parameter logic [15:0] CTRL_WORD = 16'h0700,
  parameter int          SETTLE    = 7,
  parameter int          POLL_GAP  = 2,
  parameter int          BUSY_BIT  = 15
`ifdef FIRSEQ_TIMEOUT_EN
  , parameter int        TIMEOUT   = 64
`endif
) (
  input logic              clk,
  input logic              rst,
  fir_io_sequencer_if.master io
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] COEF_ADDR = 4'd1;
  localparam logic [3:0] COEF_WR   = 4'd2;
  localparam logic [3:0] S_LATCH   = 4'd3;
  localparam logic [3:0] WR_DATA   = 4'd4;
  localparam logic [3:0] WR_START  = 4'd5;
  localparam logic [3:0] GAP       = 4'd6;
  localparam logic [3:0] WAIT      = 4'd7;
  localparam logic [3:0] RD_STAT   = 4'd8;
  localparam logic [3:0] STAT_CAP  = 4'd9;
  localparam logic [3:0] POLL_WAIT = 4'd10;
  localparam logic [3:0] RD_RES    = 4'd11;
  localparam logic [3:0] RES_CAP   = 4'd12;
  localparam logic [3:0] OUT       = 4'd13;

  logic [3:0]  state, nxt, ret, ret_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] coef_q, samp_q;
  logic        is_wr, is_rd;

`ifdef FIRSEQ_TIMEOUT_EN
  logic [15:0] pcnt;
  logic        timeout_hit;
`endif

  assign io.coef_ready = rst & (state == IDLE);
  assign io.s_ready    = rst & (state == IDLE) & ~io.coef_valid;
  assign io.busy       = (state != IDLE);

  // GAP is a shared one-cycle bus-idle state; ret says where to go after it.
  always_comb begin
    nxt     = state;
    ret_nxt = ret;
    cnt_nxt = cnt;
`ifdef FIRSEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (io.coef_valid)   nxt = io.coef_first ? COEF_ADDR : COEF_WR;
        else if (io.s_valid) nxt = S_LATCH;
      end
      COEF_ADDR: begin nxt = GAP; ret_nxt = COEF_WR; end
      COEF_WR:   begin nxt = GAP; ret_nxt = IDLE; end
      S_LATCH:   nxt = WR_DATA;
      WR_DATA:   begin nxt = GAP; ret_nxt = WR_START; end
      WR_START: begin
        nxt     = GAP;
        ret_nxt = (SETTLE == 0) ? RD_STAT : WAIT;
        cnt_nxt = 8'd0;
      end
      GAP: nxt = ret;
      WAIT: begin
        if (int'(cnt) == SETTLE - 1) nxt = RD_STAT;
        else cnt_nxt = cnt + 8'd1;
      end
      RD_STAT: nxt = STAT_CAP;
      // The capture cycle counts as the first of the POLL_GAP idle cycles.
      STAT_CAP: begin
        if (!io.io_rdata[BUSY_BIT]) nxt = RD_RES;
`ifdef FIRSEQ_TIMEOUT_EN
        else if (int'(pcnt) >= TIMEOUT) begin
          nxt         = IDLE;
          timeout_hit = 1'b1;
        end
`endif
        else if (POLL_GAP <= 1) nxt = RD_STAT;
        else begin
          nxt     = POLL_WAIT;
          cnt_nxt = 8'd0;
        end
      end
      POLL_WAIT: begin
        if (int'(cnt) == POLL_GAP - 2) nxt = RD_STAT;
        else cnt_nxt = cnt + 8'd1;
      end
      RD_RES:  nxt = RES_CAP;
      RES_CAP: nxt = OUT;
      OUT:     if (io.r_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign is_wr = (nxt == COEF_ADDR) | (nxt == COEF_WR) | (nxt == WR_DATA) | (nxt == WR_START);
  assign is_rd = (nxt == RD_STAT) | (nxt == RD_RES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ret         <= IDLE;
      cnt         <= 8'd0;
      coef_q      <= 16'd0;
      samp_q      <= 16'd0;
      io.ioaddr   <= 3'd0;
      io.iocs     <= 1'b0;
      io.iowr     <= 1'b0;
      io.iord     <= 1'b0;
      io.io_wdata <= 16'd0;
      io.r_data   <= 16'd0;
      io.r_valid  <= 1'b0;
    end else begin
      state <= nxt;
      ret   <= ret_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && io.coef_valid) coef_q <= io.coef_data;
      if (state == IDLE && !io.coef_valid && io.s_valid) samp_q <= io.s_data;

      // Bus outputs are registered from the next state, so each strobe lines up with its state.
      io.iocs <= is_wr | is_rd;
      io.iowr <= is_wr;
      io.iord <= is_rd;
      case (nxt)
        COEF_ADDR: begin io.ioaddr <= 3'd5; io.io_wdata <= 16'd0; end
        COEF_WR: begin
          io.ioaddr   <= 3'd4;
          io.io_wdata <= (state == IDLE) ? io.coef_data : coef_q;
        end
        WR_DATA:  begin io.ioaddr <= 3'd0; io.io_wdata <= samp_q; end
        WR_START: begin io.ioaddr <= 3'd2; io.io_wdata <= CTRL_WORD; end
        RD_STAT:  io.ioaddr <= 3'd2;
        RD_RES:   io.ioaddr <= 3'd0;
        default: ;
      endcase

      if (state == RES_CAP) io.r_data <= io.io_rdata;
      io.r_valid <= (nxt == OUT);
    end
  end

`ifdef FIRSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt   <= 16'd0;
      io.err <= 1'b0;
    end else begin
      if (state == S_LATCH)    pcnt <= 16'd0;
      else if (nxt == RD_STAT) pcnt <= pcnt + 16'd1;
      io.err <= timeout_hit;
    end
  end
`else
  assign io.err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_io_sequencer.sv
// Directed bench for fir_io_sequencer with a register-level FIR peripheral stub.
module tb_fir_io_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_io_sequencer_if bus();

  fir_io_sequencer #(
    .CTRL_WORD(16'h0700), .SETTLE(7), .POLL_GAP(2), .BUSY_BIT(15)
`ifdef FIRSEQ_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (.clk(clk), .rst(rst), .io(bus));

  typedef struct {
    int          cyc;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] d;
  } txn_t;

  txn_t        log_q[$];
  int          cyc = 0;
  int          proto_err = 0;
  int          err_hi = 0;
  int          rv_rises = 0;
  int          npolls = 0;
  int          poll_base = 0;
  int          busy_polls = 0;
  logic [15:0] res_val = 16'h0000;
  int          checks = 0;
  int          passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral stub: read data appears in the gap cycle after the iord strobe.
  always @(posedge clk) begin
    if (bus.iocs && bus.iord) begin
      if (bus.ioaddr == 3'd2) begin
        bus.io_rdata <= ((npolls - poll_base) < busy_polls) ? 16'h8000 : 16'h0000;
        npolls       <= npolls + 1;
      end else begin
        bus.io_rdata <= res_val;
      end
    end
  end

  // Bus monitor, sampled 1 time unit after the clock edge.
  always @(posedge clk) begin
    static logic prev_cs = 1'b0;
    static logic prev_rv = 1'b0;
    #1;
    if (bus.iocs) log_q.push_back('{cyc, bus.iowr, bus.ioaddr, bus.io_wdata});
    if (bus.iocs && prev_cs) proto_err++;
    if (bus.iocs && (bus.iowr == bus.iord)) proto_err++;
    if (!bus.iocs && (bus.iowr || bus.iord)) proto_err++;
    if (bus.err) err_hi++;
    if (bus.r_valid && !prev_rv) rv_rises++;
    prev_cs = bus.iocs;
    prev_rv = bus.r_valid;
  end

  task automatic drive_coef(input logic [15:0] d, input logic f);
    bus.coef_data = d; bus.coef_first = f; bus.coef_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.coef_ready) break;
      @(negedge clk);
    end
    if (!bus.coef_ready) begin
      checks++; $display("FAIL coef_accept: coef_ready never rose");
    end
    @(negedge clk);
    bus.coef_valid = 1'b0;
  endtask

  task automatic drive_sample(input logic [15:0] d, output int t0);
    t0 = -1;
    bus.s_data = d; bus.s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.s_ready) break;
      @(negedge clk);
    end
    if (!bus.s_ready) begin
      checks++; $display("FAIL sample_accept: s_ready never rose");
    end else t0 = cyc + 1;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_rvalid(output int rc);
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.r_valid) begin rc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL wait_idle: busy=%b required 0", bus.busy);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({bus.iocs, bus.iowr, bus.iord} !== 3'b000)
      $display("FAIL rst_strobes: got %b required 000", {bus.iocs, bus.iowr, bus.iord}); else passed++;
    checks++; if ({bus.r_valid, bus.busy, bus.err, bus.r_data} !== 19'd0)
      $display("FAIL rst_outs: got %h required 0", {bus.r_valid, bus.busy, bus.err, bus.r_data}); else passed++;
    checks++; if ({bus.s_ready, bus.coef_ready} !== 2'b00)
      $display("FAIL rst_ready: got %b required 00", {bus.s_ready, bus.coef_ready}); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({bus.s_ready, bus.coef_ready} !== 2'b11)
      $display("FAIL rst_release_ready: got %b required 11", {bus.s_ready, bus.coef_ready}); else passed++;
    @(negedge clk);
  endtask

  task automatic test_coef_load();
    logic [15:0] c [7] = '{16'd2048, 16'd4096, 16'd8192, 16'd16384, 16'd8192, 16'd4096, 16'd2048};
    int b = log_q.size();
    int pe = proto_err;
    for (int i = 0; i < 7; i++) drive_coef(c[i], i == 0);
    wait_idle();
    checks++; if (log_q.size() - b !== 8)
      $display("FAIL coef_count: got %0d required 8", log_q.size() - b); else passed++;
    if (log_q.size() - b >= 8) begin
      checks++; if ({log_q[b].wr, log_q[b].addr, log_q[b].d} !== {1'b1, 3'd5, 16'd0})
        $display("FAIL coef_addr_wr: got %b/%0d/%h required 1/5/0000", log_q[b].wr, log_q[b].addr, log_q[b].d); else passed++;
      checks++; if (log_q[b+1].cyc - log_q[b].cyc !== 2)
        $display("FAIL coef_gap: got %0d required 2", log_q[b+1].cyc - log_q[b].cyc); else passed++;
      for (int i = 0; i < 7; i++) begin
        checks++; if ({log_q[b+1+i].wr, log_q[b+1+i].addr, log_q[b+1+i].d} !== {1'b1, 3'd4, c[i]})
          $display("FAIL coef_wr%0d: got %b/%0d/%h required 1/4/%h", i, log_q[b+1+i].wr,
                   log_q[b+1+i].addr, log_q[b+1+i].d, c[i]); else passed++;
      end
    end
    checks++; if (proto_err - pe !== 0)
      $display("FAIL coef_protocol: got %0d violations required 0", proto_err - pe); else passed++;
  endtask

  task automatic test_sample();
    int t0, rc;
    int b = log_q.size();
    res_val = 16'h1000; busy_polls = 0; poll_base = npolls;
    drive_sample(16'd16384, t0);
    wait_rvalid(rc);
    checks++; if (rc - t0 !== 16)
      $display("FAIL sample_latency: got %0d required 16", rc - t0); else passed++;
    checks++; if (bus.r_data !== 16'h1000)
      $display("FAIL sample_rdata: got %h required 1000", bus.r_data); else passed++;
    checks++; if (log_q.size() - b !== 4)
      $display("FAIL sample_txn_count: got %0d required 4", log_q.size() - b); else passed++;
    if (log_q.size() - b >= 4) begin
      checks++; if ({log_q[b].cyc - t0, log_q[b].wr, log_q[b].addr, log_q[b].d} !== {32'd1, 1'b1, 3'd0, 16'h4000})
        $display("FAIL sample_wr_data: got t%0d %b/%0d/%h required t1 1/0/4000",
                 log_q[b].cyc - t0, log_q[b].wr, log_q[b].addr, log_q[b].d); else passed++;
      checks++; if ({log_q[b+1].cyc - t0, log_q[b+1].wr, log_q[b+1].addr, log_q[b+1].d} !== {32'd3, 1'b1, 3'd2, 16'h0700})
        $display("FAIL sample_wr_start: got t%0d %b/%0d/%h required t3 1/2/0700",
                 log_q[b+1].cyc - t0, log_q[b+1].wr, log_q[b+1].addr, log_q[b+1].d); else passed++;
      checks++; if ({log_q[b+2].cyc - t0, log_q[b+2].wr, log_q[b+2].addr} !== {32'd12, 1'b0, 3'd2})
        $display("FAIL sample_rd_stat: got t%0d %b/%0d required t12 0/2",
                 log_q[b+2].cyc - t0, log_q[b+2].wr, log_q[b+2].addr); else passed++;
      checks++; if ({log_q[b+3].cyc - t0, log_q[b+3].wr, log_q[b+3].addr} !== {32'd14, 1'b0, 3'd0})
        $display("FAIL sample_rd_res: got t%0d %b/%0d required t14 0/0",
                 log_q[b+3].cyc - t0, log_q[b+3].wr, log_q[b+3].addr); else passed++;
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    checks++; if ({bus.r_valid, bus.busy} !== 2'b00)
      $display("FAIL sample_handshake: r_valid/busy got %b required 00", {bus.r_valid, bus.busy}); else passed++;
  endtask

  task automatic test_busy_poll();
    int t0, rc, n;
    int stat_cyc [3];
    int b = log_q.size();
    res_val = 16'hBEEF; busy_polls = 2; poll_base = npolls;
    drive_sample(16'h1234, t0);
    wait_rvalid(rc);
    checks++; if (rc - t0 !== 22)
      $display("FAIL poll_latency: got %0d required 22", rc - t0); else passed++;
    checks++; if (bus.r_data !== 16'hBEEF)
      $display("FAIL poll_rdata: got %h required beef", bus.r_data); else passed++;
    n = 0;
    for (int i = b; i < log_q.size(); i++)
      if (!log_q[i].wr && log_q[i].addr == 3'd2) begin
        if (n < 3) stat_cyc[n] = log_q[i].cyc - t0;
        n++;
      end
    checks++; if (n !== 3)
      $display("FAIL poll_count: got %0d required 3", n); else passed++;
    if (n == 3) begin
      checks++; if ({stat_cyc[0], stat_cyc[1], stat_cyc[2]} !== {32'd12, 32'd15, 32'd18})
        $display("FAIL poll_spacing: got t%0d t%0d t%0d required t12 t15 t18",
                 stat_cyc[0], stat_cyc[1], stat_cyc[2]); else passed++;
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int t0, rc, b;
    res_val = 16'h5A5A; busy_polls = 0; poll_base = npolls;
    drive_sample(16'h0042, t0);
    wait_rvalid(rc);
    b = log_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.r_valid, bus.r_data, bus.s_ready, bus.iocs} !== {1'b1, 16'h5A5A, 1'b0, 1'b0})
        $display("FAIL hold_%0d: r_valid/r_data/s_ready/iocs got %b/%h/%b/%b required 1/5a5a/0/0",
                 i, bus.r_valid, bus.r_data, bus.s_ready, bus.iocs); else passed++;
    end
    checks++; if (log_q.size() !== b)
      $display("FAIL hold_bus_quiet: got %0d strobes required 0", log_q.size() - b); else passed++;
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    checks++; if ({bus.r_valid, bus.busy, bus.s_ready} !== 3'b001)
      $display("FAIL hold_release: r_valid/busy/s_ready got %b required 001",
               {bus.r_valid, bus.busy, bus.s_ready}); else passed++;
  endtask

  task automatic test_priority();
    int t0, rc;
    int b = log_q.size();
    res_val = 16'h0BAD; busy_polls = 0; poll_base = npolls;
    bus.coef_data = 16'h0777; bus.coef_first = 1'b0; bus.coef_valid = 1'b1;
    bus.s_data = 16'h2222; bus.s_valid = 1'b1;
    #1;
    checks++; if ({bus.coef_ready, bus.s_ready} !== 2'b10)
      $display("FAIL prio_ready: coef_ready/s_ready got %b required 10", {bus.coef_ready, bus.s_ready}); else passed++;
    @(negedge clk);
    bus.coef_valid = 1'b0;
    drive_sample(16'h2222, t0);
    wait_rvalid(rc);
    checks++; if (log_q.size() - b < 2)
      $display("FAIL prio_count: got %0d required >=2", log_q.size() - b);
    else begin
      passed++;
      checks++; if ({log_q[b].addr, log_q[b].d, log_q[b+1].addr, log_q[b+1].d} !== {3'd4, 16'h0777, 3'd0, 16'h2222})
        $display("FAIL prio_order: got %0d/%h then %0d/%h required 4/0777 then 0/2222",
                 log_q[b].addr, log_q[b].d, log_q[b+1].addr, log_q[b+1].d); else passed++;
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t0, b, rv;
    res_val = 16'h7777; busy_polls = 0; poll_base = npolls;
    drive_sample(16'h0101, t0);
    while (cyc < t0 + 8) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.iocs, bus.iowr, bus.iord, bus.busy} !== 4'b0000)
      $display("FAIL rst_wait: iocs/iowr/iord/busy got %b required 0000",
               {bus.iocs, bus.iowr, bus.iord, bus.busy}); else passed++;
    @(negedge clk);
    rst = 1'b1;
    drive_sample(16'h0202, t0);
    while (cyc < t0 + 12) @(negedge clk);
    checks++; if ({bus.iocs, bus.iord} !== 2'b11)
      $display("FAIL pre_rst_strobe: iocs/iord got %b required 11", {bus.iocs, bus.iord}); else passed++;
    #1 rst = 1'b0;
    #1;
    checks++; if ({bus.iocs, bus.iowr, bus.iord} !== 3'b000)
      $display("FAIL rst_strobe_drop: got %b required 000", {bus.iocs, bus.iowr, bus.iord}); else passed++;
    @(negedge clk);
    rst = 1'b1;
    b = log_q.size(); rv = rv_rises;
    #1;
    checks++; if ({bus.s_ready, bus.busy} !== 2'b10)
      $display("FAIL rst_release_idle: s_ready/busy got %b required 10", {bus.s_ready, bus.busy}); else passed++;
    repeat (30) @(negedge clk);
    checks++; if ({log_q.size() - b, rv_rises - rv} !== {32'd0, 32'd0})
      $display("FAIL rst_discard: strobes %0d r_valid rises %0d required 0 0",
               log_q.size() - b, rv_rises - rv); else passed++;
  endtask

`ifdef FIRSEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t0, n;
    int b = log_q.size();
    int e = err_hi;
    int rv = rv_rises;
    busy_polls = 1000; poll_base = npolls;
    drive_sample(16'h0303, t0);
    wait_idle();
    n = 0;
    for (int i = b; i < log_q.size(); i++) if (!log_q[i].wr && log_q[i].addr == 3'd2) n++;
    checks++; if (n !== 4) $display("FAIL timeout_polls: got %0d required 4", n); else passed++;
    @(negedge clk);
    checks++; if (err_hi - e !== 1) $display("FAIL timeout_err: got %0d err cycles required 1", err_hi - e); else passed++;
    checks++; if (rv_rises - rv !== 0) $display("FAIL timeout_rvalid: got %0d required 0", rv_rises - rv); else passed++;
  endtask
`endif

  initial begin
    bus.s_data = '0; bus.s_valid = 1'b0;
    bus.coef_data = '0; bus.coef_first = 1'b0; bus.coef_valid = 1'b0;
    bus.r_ready = 1'b0;
    bus.io_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_coef_load();
    test_sample();
    test_busy_poll();
    test_backpressure();
    test_priority();
    test_reset_mid();
`ifdef FIRSEQ_TIMEOUT_EN
    test_timeout();
`else
    checks++; if (err_hi !== 0) $display("FAIL err_tied: got %0d err cycles required 0", err_hi); else passed++;
`endif
    checks++; if (proto_err !== 0)
      $display("FAIL protocol: got %0d violations required 0", proto_err); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fir_io_sequencer.md
Name: fir_io_sequencer

Overview:
- Bus-master sequencer that drives the 3-bit I/O register port of the 128-tap FIR filter peripheral.
- Loads coefficients from a coefficient stream and feeds samples from a sample stream.
- Per sample it issues data-write, start, status polling and result-read transactions, then presents each result on a result stream.
- Sits between the DSP sample path and the FIR peripheral, replacing CPU-driven register access.

Parameters:
- CTRL_WORD, 16'h0700: value written to the start/control register (addr 2) for each sample.
- SETTLE, 7: idle cycles after the start write before the first status poll; range 0..255.
- POLL_GAP, 2: idle cycles between consecutive status polls while busy; range 0..255.
- BUSY_BIT, 15: status bit index; 1 = filter still running.
- TIMEOUT, 64: maximum status polls per sample; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- s_data  in  16  input sample.
- s_valid  in  1  sample offered.
- s_ready  out  1  sample accepted when s_valid & s_ready at a clk edge.
- coef_data  in  16  coefficient value.
- coef_first  in  1  marks the first coefficient of a set.
- coef_valid  in  1  coefficient offered.
- coef_ready  out  1  coefficient accepted when coef_valid & coef_ready.
- r_data  out  16  filter result.
- r_valid  out  1  result available.
- r_ready  in  1  result consumed when r_valid & r_ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- ioaddr  out  3  peripheral register address.
- iocs  out  1  peripheral chip select.
- iowr  out  1  write strobe.
- iord  out  1  read strobe.
- io_wdata  out  16  write data to the peripheral.
- io_rdata  in  16  read data from the peripheral.
- err  out  1  timeout pulse; tied to 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; ioaddr=0, iocs=0, iowr=0, iord=0, io_wdata=0, r_data=0, r_valid=0, busy=0, err=0, all counters 0. s_ready and coef_ready are 0 while rst=0.
- Reset asserted mid-transaction: strobes drop immediately, any pending sample or result is discarded, and no partial bus cycle completes.
- All bus outputs are registered.
- Each transaction is exactly one strobe cycle with iocs=1 plus iowr or iord, then one gap cycle with all strobes 0.
- Read data is captured from io_rdata in the gap cycle that follows the iord strobe.
- Peripheral register map: 0 = sample write / result read; 2 = control write / status read; 4 = coefficient write (auto-increment); 5 = coefficient address write.
- coef_ready = (state==IDLE). s_ready = (state==IDLE) & ~coef_valid. Coefficients take priority over samples in IDLE.
- Coefficient path:
  - Accepted with coef_first=1: COEF_ADDR (write addr5 = 0), gap, COEF_WR (write addr4 = coef_data), gap, IDLE.
  - Accepted with coef_first=0: COEF_WR, gap, IDLE.
  - The coefficient value is latched at acceptance.
- Sample path, from the accepting edge T0:
  - T1: WR_DATA (addr0 = sample). T2: gap.
  - T3: WR_START (addr2 = CTRL_WORD). T4: gap.
  - SETTLE cycles of WAIT.
  - RD_STAT strobe, then capture.
  - If io_rdata[BUSY_BIT]=1: POLL_GAP idle cycles, then RD_STAT again.
  - If 0: RD_RES (addr0 read) strobe, then capture into r_data, then OUT.
  - With no busy polls, r_valid rises at T9+SETTLE (T16 at default SETTLE).
- OUT: r_valid=1 and r_data held stable until r_valid & r_ready, then IDLE on the next edge. r_valid drops on that edge, and no new sample is accepted in the same cycle.
- Status and result reads are ignored in all other states. No bus activity occurs in IDLE.

Optional Feature:
- Macro FIRSEQ_TIMEOUT_EN.
- Defined: a poll counter increments on each RD_STAT. When the count reaches TIMEOUT with the status still busy, err pulses high for one cycle, the sample is dropped, no r_valid is produced, and the FSM returns to IDLE.
- Undefined: status is polled indefinitely, no counter is synthesised, and err is a constant 0.

Test Plan:
- Coefficient set 2048, 4096, 8192, 16384, 8192, 4096, 2048, first flagged -> bus shows addr5←0 then seven addr4 writes in order; every strobe is exactly 1 cycle with a 1-cycle gap.
- Sample 16384; stub status 0x0000, result 0x1000 -> writes addr0←0x4000 and addr2←0x0700, one status read, one result read; r_data=0x1000 with r_valid at T16.
- Stub status 0x8000 for the first 2 polls -> 3 status reads spaced 1+POLL_GAP cycles apart (counted strobe to gap to next strobe); r_valid at T22.
- r_ready held low 5 cycles in OUT -> r_valid and r_data stable, s_ready=0, no bus activity; IDLE on the handshake edge.
- coef_valid and s_valid both high in IDLE -> coefficient write sequence first, then sample accepted.
- rst low during WAIT -> iocs, iowr and iord are 0 in the same cycle; after release, IDLE with s_ready=1.
- With FIRSEQ_TIMEOUT_EN, TIMEOUT=4, status stuck at 0x8000 -> 4 status reads, one-cycle err pulse, no r_valid, return to IDLE.
